// File: rtl/brick_hit_handler.sv
// -----------------------------------------------------------------------------
// brick_hit_handler
//   Read-modify-write controller sitting in front of brick_memory. It is the
//   only driver of the memory's coordinate, write-enable and write-data inputs.
//   - load_req sweeps the whole grid row-major, writing INIT_HEALTH to each cell
//     (one cell per cycle, GRID_W*GRID_H cycles).
//   - hit_req reads the struck cell, decrements a nonzero health and writes it
//     back, then pulses hit_done with hit_brick/destroyed.
//   - bricks_left counts live bricks; level_clear is set when a hit destroys
//     the last one and is cleared by the next load.
//
// Optional feature: define BRICK_SCORE_EN to add the 16-bit saturating
// 'score' output (+1 per brick hit, +4 extra when the brick is destroyed).
//
// Ports
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   load_req, hit_req     single-cycle request pulses, sampled only in IDLE
//   hit_x, hit_y          struck-cell coordinates, sampled with hit_req
//   mem_health            brick_memory read data (READ_LAT cycles after address)
//   mem_x, mem_y          brick_memory coordinates
//   mem_wren              brick_memory write enable (LOAD and WRITE only)
//   mem_health_out        brick_memory write data
//   busy                  high whenever the controller is not idle
//   hit_done              one-cycle pulse when a hit has been resolved
//   hit_brick, destroyed  hit result, valid with hit_done
//   bricks_left           live brick count
//   level_clear           sticky level-cleared flag
//   score                 (BRICK_SCORE_EN only) saturating score
// -----------------------------------------------------------------------------
module brick_hit_handler #(
    parameter int unsigned GRID_W      = 16,
    parameter int unsigned GRID_H      = 16,
    parameter int unsigned READ_LAT    = 2,
    parameter logic [1:0]  INIT_HEALTH = 2'd3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_req,
    input  logic        hit_req,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    input  logic [1:0]  mem_health,
    output logic [9:0]  mem_x,
    output logic [9:0]  mem_y,
    output logic        mem_wren,
    output logic [1:0]  mem_health_out,
    output logic        busy,
    output logic        hit_done,
    output logic        hit_brick,
    output logic        destroyed,
    output logic [8:0]  bricks_left,
    output logic        level_clear
`ifdef BRICK_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    localparam logic [9:0] X_LAST   = 10'(GRID_W - 1);
    localparam logic [9:0] Y_LAST   = 10'(GRID_H - 1);
    localparam logic [8:0] TOTAL    = 9'(GRID_W * GRID_H);
    localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DECIDE,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic [1:0] health_q;

`ifdef BRICK_SCORE_EN
    logic [16:0] score_sum;

    // In WRITE, mem_health_out holds the new health: zero means destroyed.
    always_comb begin
        score_sum = {1'b0, score} + ((mem_health_out == 2'd0) ? 17'd5 : 17'd1);
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            health_q       <= '0;
            mem_x          <= '0;
            mem_y          <= '0;
            mem_wren       <= 1'b0;
            mem_health_out <= '0;
            busy           <= 1'b0;
            hit_done       <= 1'b0;
            hit_brick      <= 1'b0;
            destroyed      <= 1'b0;
            bricks_left    <= '0;
            level_clear    <= 1'b0;
`ifdef BRICK_SCORE_EN
            score          <= '0;
`endif
        end else begin
            hit_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        state          <= LOAD;
                        busy           <= 1'b1;
                        mem_x          <= '0;
                        mem_y          <= '0;
                        mem_wren       <= 1'b1;
                        mem_health_out <= INIT_HEALTH;
                        level_clear    <= 1'b0;
                    end else if (hit_req) begin
                        busy      <= 1'b1;
                        hit_brick <= 1'b0;
                        destroyed <= 1'b0;
                        if (hit_x > X_LAST || hit_y > Y_LAST) begin
                            // Off-grid: report a miss without touching memory.
                            state    <= DONE;
                            hit_done <= 1'b1;
                        end else begin
                            state    <= READ;
                            mem_x    <= hit_x;
                            mem_y    <= hit_y;
                            wait_cnt <= '0;
                        end
                    end
                end

                LOAD: begin
                    if (mem_x == X_LAST && mem_y == Y_LAST) begin
                        // Last cell written; coordinates hold on it while idle.
                        state       <= IDLE;
                        busy        <= 1'b0;
                        mem_wren    <= 1'b0;
                        bricks_left <= TOTAL;
                        level_clear <= 1'b0;
                    end else if (mem_x == X_LAST) begin
                        mem_x <= '0;
                        mem_y <= mem_y + 10'd1;
                    end else begin
                        mem_x <= mem_x + 10'd1;
                    end
                end

                READ: begin
                    if (wait_cnt == LAT_LAST) begin
                        state    <= DECIDE;
                        health_q <= mem_health;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                DECIDE: begin
                    if (health_q == 2'd0) begin
                        state    <= DONE;
                        hit_done <= 1'b1;
                    end else begin
                        state          <= WRITE;
                        mem_wren       <= 1'b1;
                        mem_health_out <= health_q - 2'd1;
                    end
                end

                WRITE: begin
                    state     <= DONE;
                    mem_wren  <= 1'b0;
                    hit_done  <= 1'b1;
                    hit_brick <= 1'b1;
                    if (mem_health_out == 2'd0) begin
                        destroyed <= 1'b1;
                        if (bricks_left != '0) begin
                            bricks_left <= bricks_left - 9'd1;
                        end
                        if (bricks_left == 9'd1) begin
                            level_clear <= 1'b1;
                        end
                    end
`ifdef BRICK_SCORE_EN
                    score <= score_sum[16] ? '1 : score_sum[15:0];
`endif
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brick_hit_handler.sv
// -----------------------------------------------------------------------------
// tb_brick_hit_handler
//   Two instances: a 16x16 grid (index 0) and a 2x2 grid (index 1), each with a
//   behavioural brick_memory whose read data appears READ_LAT(=2) cycles after
//   the address is first driven. Expected results come from a per-cell health
//   table updated by the game rules, not from the controller's state machine.
// -----------------------------------------------------------------------------
module tb_brick_hit_handler;

    localparam int READ_LAT = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic       load_req [2];
    logic       hit_req [2];
    logic [9:0] hit_x [2];
    logic [9:0] hit_y [2];
    logic [1:0] mem_health [2];
    logic [9:0] mem_x [2];
    logic [9:0] mem_y [2];
    logic       mem_wren [2];
    logic [1:0] mem_health_out [2];
    logic       busy [2];
    logic       hit_done [2];
    logic       hit_brick [2];
    logic       destroyed [2];
    logic [8:0] bricks_left [2];
    logic       level_clear [2];
`ifdef BRICK_SCORE_EN
    logic [15:0] score [2];
`endif

    brick_hit_handler #(
        .GRID_W(16), .GRID_H(16), .READ_LAT(READ_LAT), .INIT_HEALTH(2'd3)
    ) u_dut (
        .clk(clk), .resetn(resetn),
        .load_req(load_req[0]), .hit_req(hit_req[0]),
        .hit_x(hit_x[0]), .hit_y(hit_y[0]),
        .mem_health(mem_health[0]),
        .mem_x(mem_x[0]), .mem_y(mem_y[0]),
        .mem_wren(mem_wren[0]), .mem_health_out(mem_health_out[0]),
        .busy(busy[0]), .hit_done(hit_done[0]),
        .hit_brick(hit_brick[0]), .destroyed(destroyed[0]),
        .bricks_left(bricks_left[0]), .level_clear(level_clear[0])
`ifdef BRICK_SCORE_EN
        , .score(score[0])
`endif
    );

    brick_hit_handler #(
        .GRID_W(2), .GRID_H(2), .READ_LAT(READ_LAT), .INIT_HEALTH(2'd3)
    ) u_small (
        .clk(clk), .resetn(resetn),
        .load_req(load_req[1]), .hit_req(hit_req[1]),
        .hit_x(hit_x[1]), .hit_y(hit_y[1]),
        .mem_health(mem_health[1]),
        .mem_x(mem_x[1]), .mem_y(mem_y[1]),
        .mem_wren(mem_wren[1]), .mem_health_out(mem_health_out[1]),
        .busy(busy[1]), .hit_done(hit_done[1]),
        .hit_brick(hit_brick[1]), .destroyed(destroyed[1]),
        .bricks_left(bricks_left[1]), .level_clear(level_clear[1])
`ifdef BRICK_SCORE_EN
        , .score(score[1])
`endif
    );

    // Behavioural memories: one read register stage after a combinational
    // lookup gives data READ_LAT=2 cycles after the address edge.
    logic [1:0] mem0 [256];
    logic [1:0] mem1 [4];
    logic [1:0] rd0, rd1;
    int         wc [2];

    initial begin
        wc[0] = 0;
        wc[1] = 0;
    end

    always @(posedge clk) begin
        if (mem_wren[0]) begin
            mem0[{mem_y[0][3:0], mem_x[0][3:0]}] <= mem_health_out[0];
            wc[0] <= wc[0] + 1;
        end
        if (mem_wren[1]) begin
            mem1[{mem_y[1][0], mem_x[1][0]}] <= mem_health_out[1];
            wc[1] <= wc[1] + 1;
        end
        rd0 <= mem0[{mem_y[0][3:0], mem_x[0][3:0]}];
        rd1 <= mem1[{mem_y[1][0], mem_x[1][0]}];
    end

    assign mem_health[0] = rd0;
    assign mem_health[1] = rd1;

    // Reference state.
    int ref_h [2][256];
    int ref_bricks [2];
    int ref_clear [2];
    int ref_score [2];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gw(input int s);
        return (s == 1) ? 2 : 16;
    endfunction

    function automatic int gh(input int s);
        return (s == 1) ? 2 : 16;
    endfunction

    function automatic int mem_cell(input int s, input int idx);
        logic [7:0] a;
        a = 8'(idx);
        if (s == 1) return int'(mem1[a[1:0]]);
        return int'(mem0[a]);
    endfunction

    task automatic check_reset_values(input int s);
        check("rst_mem_x", mem_x[s], 0);
        check("rst_mem_y", mem_y[s], 0);
        check("rst_mem_wren", mem_wren[s], 0);
        check("rst_mem_health_out", mem_health_out[s], 0);
        check("rst_busy", busy[s], 0);
        check("rst_hit_done", hit_done[s], 0);
        check("rst_hit_brick", hit_brick[s], 0);
        check("rst_destroyed", destroyed[s], 0);
        check("rst_bricks_left", bricks_left[s], 0);
        check("rst_level_clear", level_clear[s], 0);
`ifdef BRICK_SCORE_EN
        check("rst_score", score[s], 0);
`endif
    endtask

    // mode 0: plain load; 1: hit_req pulsed mid-load; 2: hit_req coincident with load_req
    task automatic do_load(input int s, input int mode);
        int n, bad, hd, w0, total;
        total = gw(s) * gh(s);
        n = 0; bad = 0; hd = 0;
        @(negedge clk);
        w0 = wc[s];
        load_req[s] = 1'b1;
        if (mode == 2) begin
            hit_req[s] = 1'b1; hit_x[s] = 10'd0; hit_y[s] = 10'd0;
        end
        @(negedge clk);
        load_req[s] = 1'b0;
        hit_req[s]  = 1'b0;
        while (busy[s] && n < 2000) begin
            if (hit_done[s]) hd++;
            n++;
            if (mode == 1 && n == 10) begin
                hit_req[s] = 1'b1; hit_x[s] = 10'd1; hit_y[s] = 10'd0;
            end else begin
                hit_req[s] = 1'b0;
            end
            @(negedge clk);
        end
        hit_req[s] = 1'b0;
        repeat (6) begin
            if (hit_done[s]) hd++;
            @(negedge clk);
        end
        for (int i = 0; i < total; i++) begin
            if (mem_cell(s, i) != 3) bad++;
        end
        check("load_busy_cycles", n, total);
        check("load_no_hit_done", hd, 0);
        check("load_wren_count", wc[s] - w0, total);
        check("load_cells_init", bad, 0);
        check("load_bricks_left", bricks_left[s], total);
        check("load_level_clear", level_clear[s], 0);
        check("load_hold_x", mem_x[s], gw(s) - 1);
        check("load_hold_y", mem_y[s], gh(s) - 1);
        for (int i = 0; i < total; i++) ref_h[s][i] = 3;
        ref_bricks[s] = total;
        ref_clear[s]  = 0;
    endtask

    task automatic do_hit(input int s, input int x, input int y);
        int lat, w0, idx, h, exp_lat, exp_hb, exp_des, exp_w;
        bit inr;
        inr = (x < gw(s)) && (y < gh(s));
        idx = inr ? (y * gw(s) + x) : 0;
        h   = inr ? ref_h[s][idx] : 0;
        exp_hb  = (inr && h > 0) ? 1 : 0;
        exp_des = (exp_hb == 1 && h == 1) ? 1 : 0;
        exp_w   = exp_hb;
        exp_lat = !inr ? 1 : ((h > 0) ? READ_LAT + 3 : READ_LAT + 2);
        if (exp_hb == 1) begin
            ref_h[s][idx] = h - 1;
            ref_score[s] = ref_score[s] + (exp_des ? 5 : 1);
            if (ref_score[s] > 65535) ref_score[s] = 65535;
            if (exp_des == 1 && ref_bricks[s] > 0) begin
                ref_bricks[s]--;
                if (ref_bricks[s] == 0) ref_clear[s] = 1;
            end
        end
        @(negedge clk);
        w0 = wc[s];
        hit_req[s] = 1'b1;
        hit_x[s]   = 10'(x);
        hit_y[s]   = 10'(y);
        @(negedge clk);
        hit_req[s] = 1'b0;
        lat = 1;
        while (!hit_done[s] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("hit_latency", lat, exp_lat);
        check("hit_brick", hit_brick[s], exp_hb);
        check("hit_destroyed", destroyed[s], exp_des);
        check("hit_wren_count", wc[s] - w0, exp_w);
        check("hit_bricks_left", bricks_left[s], ref_bricks[s]);
        check("hit_level_clear", level_clear[s], ref_clear[s]);
`ifdef BRICK_SCORE_EN
        check("hit_score", score[s], ref_score[s]);
`endif
        if (inr) check("hit_cell_health", mem_cell(s, idx), ref_h[s][idx]);
        @(negedge clk);
        check("hit_done_one_cycle", hit_done[s], 0);
        check("hit_busy_released", busy[s], 0);
    endtask

    initial begin
        int n;
`ifdef BRICK_SCORE_EN
        int sc0;
`endif
        for (int s = 0; s < 2; s++) begin
            load_req[s] = 1'b0; hit_req[s] = 1'b0;
            hit_x[s] = '0; hit_y[s] = '0;
            ref_bricks[s] = 0; ref_clear[s] = 0; ref_score[s] = 0;
        end

        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) check_reset_values(s);
        resetn = 1'b1;
        @(negedge clk);

        // Load, with a hit request arriving mid-sweep that must be dropped.
        do_load(0, 1);

        // Three hits on (5,2): 3 -> 2 -> 1 -> 0, destroyed on the third.
`ifdef BRICK_SCORE_EN
        sc0 = int'(score[0]);
`endif
        do_hit(0, 5, 2);
        do_hit(0, 5, 2);
        do_hit(0, 5, 2);
        check("cell_5_2_dead", mem_cell(0, 2 * 16 + 5), 0);
        check("bricks_after_destroy", bricks_left[0], 255);
`ifdef BRICK_SCORE_EN
        check("score_three_hits", int'(score[0]) - sc0, 7);
`endif
        // Dead cell and off-grid hits.
        do_hit(0, 5, 2);
        do_hit(0, 16, 0);
        do_hit(0, 0, 16);
        do_hit(0, 1023, 1023);

        // load_req wins over a coincident hit_req.
        do_load(0, 2);
        do_hit(0, 5, 2);

        // Random hits concentrated on a 5x5 corner, occasionally off-grid.
        for (int k = 0; k < 80; k++) begin
            int rx, ry;
            if ($urandom_range(7, 0) == 0) begin
                rx = int'($urandom_range(1023, 16));
                ry = int'($urandom_range(15, 0));
            end else begin
                rx = int'($urandom_range(4, 0));
                ry = int'($urandom_range(4, 0));
            end
            do_hit(0, rx, ry);
        end

        // Small grid: destroy every brick, then reload.
        do_load(1, 0);
        for (int c = 0; c < 4; c++) begin
            repeat (3) do_hit(1, c % 2, c / 2);
        end
        check("small_level_clear", level_clear[1], 1);
        check("small_bricks_zero", bricks_left[1], 0);
        do_hit(1, 0, 0);
        check("small_bricks_saturate", bricks_left[1], 0);
        do_load(1, 0);
        check("small_reload_clear", level_clear[1], 0);
        check("small_reload_bricks", bricks_left[1], 4);

        // Reset in the middle of a load, while cell 100 is being written.
        @(negedge clk);
        load_req[0] = 1'b1;
        @(negedge clk);
        load_req[0] = 1'b0;
        n = 0;
        while (!(mem_y[0] == 10'd6 && mem_x[0] == 10'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_cell_100", int'(mem_y[0]) * 16 + int'(mem_x[0]), 100);
        resetn = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) check_reset_values(s);
        @(posedge clk);
        #1;
        check_reset_values(0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", busy[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
